// File: rtl/register_sequencer.sv
// Register sequencer: turns one accepted request into a burst of enable pulses for a 16-bit register and keeps a shadow copy of that register.
// Latency: first pulse in the cycle after acceptance, Done one cycle after the last pulse. All outputs are registered.
// Backpressure: ReqReady is high only while idle, and a request offered at any other time is ignored.
module register_sequencer #(
    parameter int COUNT_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [1:0]         ReqOp,
    input  logic [COUNT_W-1:0] ReqCount,
    input  logic [15:0]        ReqData,
    output logic               RegE,
    output logic [1:0]         RegFunSel,
    output logic [15:0]        RegI,
    output logic [15:0]        Shadow,
    output logic               Busy,
    output logic               Done,
    output logic               Zero
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [1:0]         op_q;
    logic [15:0]        data_q;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic               accept;
    logic [1:0]         op_sel;
    logic [15:0]        data_sel;
    logic               e_d;
    logic [1:0]         fun_d;
    logic [15:0]        i_d;
    logic [15:0]        shadow_d;

    assign accept   = ReqValid && ReqReady;
    assign op_sel   = accept ? ReqOp : op_q;
    assign data_sel = accept ? ReqData : data_q;
    assign Zero     = (Shadow == 16'h0000);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_d;
        end
    end

    // INIT is entered with RegE low (reset value), so seeing RegE low in INIT means the clear pulse is still owed.
    always_comb begin
        state_d = state;
        rem_d   = rem_q;
        case (state)
            ST_INIT: begin
                state_d = RegE ? ST_IDLE : ST_INIT;
            end
            ST_IDLE: begin
                if (accept) begin
                    if (ReqOp[1]) begin
                        state_d = ST_ISSUE;
                        rem_d   = '0;
                    end else if (ReqCount == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        rem_d   = ReqCount - COUNT_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    rem_d = rem_q - COUNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        e_d   = (state_d == ST_INIT) || (state_d == ST_ISSUE);
        fun_d = 2'b00;
        i_d   = 16'h0000;
        if (state_d == ST_INIT) begin
            fun_d = 2'b11;
        end else if (state_d == ST_ISSUE) begin
            fun_d = op_sel;
            if (op_sel == 2'b10) begin
                i_d = data_sel;
            end
        end
    end

    always_comb begin
        shadow_d = Shadow;
        if (RegE) begin
            case (RegFunSel)
                2'b00:   shadow_d = Shadow - 16'd1;
                2'b01:   shadow_d = Shadow + 16'd1;
                2'b10:   shadow_d = RegI;
                default: shadow_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rem_q     <= '0;
            op_q      <= 2'b00;
            data_q    <= 16'h0000;
            RegE      <= 1'b0;
            RegFunSel <= 2'b00;
            RegI      <= 16'h0000;
            Shadow    <= 16'h0000;
            Busy      <= 1'b1;
            Done      <= 1'b0;
            ReqReady  <= 1'b0;
        end else begin
            rem_q <= rem_d;
            if (accept) begin
                op_q   <= ReqOp;
                data_q <= ReqData;
            end
            RegE      <= e_d;
            RegFunSel <= fun_d;
            RegI      <= i_d;
            Shadow    <= shadow_d;
            Busy      <= (state_d != ST_IDLE);
            Done      <= (state_d == ST_DONE);
            ReqReady  <= (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_register_sequencer.sv
// Bench for register_sequencer: a schedule-of-cycles reference model checked every cycle, plus directed literal checks.
module tb_register_sequencer;
    localparam int COUNT_W = 8;

    logic               Clock = 1'b0;
    logic               Reset = 1'b1;
    logic               ReqValid = 1'b0;
    logic [1:0]         ReqOp = 2'b00;
    logic [COUNT_W-1:0] ReqCount = '0;
    logic [15:0]        ReqData = 16'h0000;
    logic               ReqReady;
    logic               RegE;
    logic [1:0]         RegFunSel;
    logic [15:0]        RegI;
    logic [15:0]        Shadow;
    logic               Busy;
    logic               Done;
    logic               Zero;

    int checks = 0;
    int errors = 0;

    register_sequencer #(.COUNT_W(COUNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp(ReqOp), .ReqCount(ReqCount), .ReqData(ReqData),
        .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI), .Shadow(Shadow),
        .Busy(Busy), .Done(Done), .Zero(Zero)
    );

    always #5 Clock = ~Clock;

    // One record describes what every output except Shadow/Zero must be for one cycle.
    typedef struct packed {
        logic        e;
        logic [1:0]  fun;
        logic [15:0] i;
        logic        busy;
        logic        done;
        logic        ready;
    } rec_t;

    rec_t        plan[$];
    rec_t        cur;
    logic [15:0] m_shadow = 16'h0000;
    bit          model_valid = 1'b0;
    bit          pending_clear = 1'b0;

    function automatic rec_t mk(input logic e, input logic [1:0] fun, input logic [15:0] i,
                                input logic busy, input logic done, input logic ready);
        rec_t r;
        r.e = e; r.fun = fun; r.i = i; r.busy = busy; r.done = done; r.ready = ready;
        return r;
    endfunction

    // Reference model: an accepted request expands into N pulse cycles followed by one Done cycle.
    always @(posedge Clock) begin
        int n;
        if (Reset) begin
            plan.delete();
            cur = mk(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 1'b0);
            m_shadow = 16'h0000;
            pending_clear = 1'b1;
        end else begin
            if (cur.e) begin
                case (cur.fun)
                    2'b00:   m_shadow = m_shadow - 16'd1;
                    2'b01:   m_shadow = m_shadow + 16'd1;
                    2'b10:   m_shadow = cur.i;
                    default: m_shadow = 16'h0000;
                endcase
            end
            if (pending_clear) begin
                cur = mk(1'b1, 2'b11, 16'h0, 1'b1, 1'b0, 1'b0);
                pending_clear = 1'b0;
            end else if (cur.ready && ReqValid) begin
                n = ReqOp[1] ? 1 : int'(ReqCount);
                for (int p = 0; p < n; p++)
                    plan.push_back(mk(1'b1, ReqOp, (ReqOp == 2'b10) ? ReqData : 16'h0, 1'b1, 1'b0, 1'b0));
                plan.push_back(mk(1'b0, 2'b00, 16'h0, 1'b1, 1'b1, 1'b0));
                cur = plan.pop_front();
            end else if (plan.size() > 0) begin
                cur = plan.pop_front();
            end else begin
                cur = mk(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1);
            end
        end
        model_valid = 1'b1;
    end

    always @(negedge Clock) begin
        logic [38:0] act_v;
        logic [38:0] exp_v;
        if (model_valid) begin
            act_v = {RegE, RegFunSel, RegI, Shadow, Zero, Busy, Done, ReqReady};
            exp_v = {cur.e, cur.fun, cur.i, m_shadow, (m_shadow == 16'h0000), cur.busy, cur.done, cur.ready};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t actual={E,Fun,I,Shadow,Zero,Busy,Done,Ready}=%h required=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ReqReady && k < 300) begin
            @(negedge Clock);
            k++;
        end
        checks++;
        if (!ReqReady) begin
            errors++;
            $display("FAIL wait_ready t=%0t actual=ReqReady 0 required=1 within 300 cycles", $time);
        end
    endtask

    // Returns at the negedge of the cycle after acceptance, with the inputs scrambled.
    task automatic issue(input logic [1:0] op, input logic [COUNT_W-1:0] cnt, input logic [15:0] data);
        wait_ready();
        ReqValid = 1'b1; ReqOp = op; ReqCount = cnt; ReqData = data;
        @(posedge Clock);
        @(negedge Clock);
        ReqValid = 1'b0;
        ReqOp    = 2'($urandom_range(0, 3));
        ReqCount = COUNT_W'($urandom);
        ReqData  = 16'($urandom);
    endtask

    initial begin
        logic [15:0] picks [4];
        picks[0] = 16'h0000; picks[1] = 16'h0001; picks[2] = 16'hFFFF; picks[3] = 16'hFFFE;

        // Reset for two cycles, then the INIT clear pulse, then idle.
        repeat (2) @(negedge Clock);
        chk("rst_ready", 16'(ReqReady), 16'h0);
        chk("rst_busy", 16'(Busy), 16'h1);
        chk("rst_rege", 16'(RegE), 16'h0);
        chk("rst_shadow", Shadow, 16'h0000);
        chk("rst_zero", 16'(Zero), 16'h1);
        Reset = 1'b0;
        @(negedge Clock);
        chk("init_rege", 16'(RegE), 16'h1);
        chk("init_fun", 16'(RegFunSel), 16'h3);
        @(negedge Clock);
        chk("idle_ready", 16'(ReqReady), 16'h1);
        chk("idle_zero", 16'(Zero), 16'h1);

        // Load 0x1234.
        issue(2'b10, COUNT_W'(7), 16'h1234);
        chk("load_rege", 16'(RegE), 16'h1);
        chk("load_fun", 16'(RegFunSel), 16'h2);
        chk("load_regi", RegI, 16'h1234);
        @(negedge Clock);
        chk("load_done", 16'(Done), 16'h1);
        chk("load_shadow", Shadow, 16'h1234);
        @(negedge Clock);
        chk("load_ready", 16'(ReqReady), 16'h1);

        // 0x0001 stepped down three times passes through zero and wraps.
        issue(2'b10, '0, 16'h0001);
        issue(2'b00, COUNT_W'(3), 16'h0);
        chk("dn1_shadow", Shadow, 16'h0001);
        chk("dn1_zero", 16'(Zero), 16'h0);
        @(negedge Clock);
        chk("dn2_rege", 16'(RegE), 16'h1);
        chk("dn2_shadow", Shadow, 16'h0000);
        chk("dn2_zero", 16'(Zero), 16'h1);
        @(negedge Clock);
        chk("dn3_fun", 16'(RegFunSel), 16'h0);
        chk("dn3_shadow", Shadow, 16'hFFFF);
        @(negedge Clock);
        chk("dn_done", 16'(Done), 16'h1);
        chk("dn_shadow", Shadow, 16'hFFFE);
        chk("dn_zero", 16'(Zero), 16'h0);

        // 0xFFFF + 1 wraps to zero.
        issue(2'b10, '0, 16'hFFFF);
        issue(2'b01, COUNT_W'(1), 16'h0);
        chk("up_fun", 16'(RegFunSel), 16'h1);
        @(negedge Clock);
        chk("up_shadow", Shadow, 16'h0000);
        chk("up_zero", 16'(Zero), 16'h1);

        // Zero-count step: Done next cycle, no pulse.
        issue(2'b10, '0, 16'h5555);
        issue(2'b01, '0, 16'h0);
        chk("z_done", 16'(Done), 16'h1);
        chk("z_rege", 16'(RegE), 16'h0);
        chk("z_shadow", Shadow, 16'h5555);

        // Step-up by 10 aborted by reset after four pulses, with ReqValid held throughout.
        wait_ready();
        ReqValid = 1'b1; ReqOp = 2'b01; ReqCount = COUNT_W'(10); ReqData = 16'h0;
        @(posedge Clock);
        repeat (4) @(negedge Clock);
        chk("ab_rege", 16'(RegE), 16'h1);
        chk("ab_shadow", Shadow, 16'h5558);
        Reset = 1'b1;
        @(negedge Clock);
        chk("ab_done", 16'(Done), 16'h0);
        chk("ab_rst_rege", 16'(RegE), 16'h0);
        chk("ab_rst_shadow", Shadow, 16'h0000);
        chk("ab_rst_ready", 16'(ReqReady), 16'h0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("ab_init_fun", 16'(RegFunSel), 16'h3);
        chk("ab_init_ready", 16'(ReqReady), 16'h0);
        ReqValid = 1'b0;
        @(negedge Clock);
        chk("ab_idle_ready", 16'(ReqReady), 16'h1);
        chk("ab_idle_shadow", Shadow, 16'h0000);

        // Random traffic, with occasional resets.
        repeat (4000) begin
            @(negedge Clock);
            Reset    = ($urandom_range(0, 299) == 0);
            ReqValid = 1'($urandom_range(0, 1));
            ReqOp    = 2'($urandom_range(0, 3));
            ReqCount = ($urandom_range(0, 15) == 0) ? COUNT_W'($urandom_range(0, 40))
                                                    : COUNT_W'($urandom_range(0, 5));
            ReqData  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : 16'($urandom);
        end
        Reset = 1'b0;
        ReqValid = 1'b0;
        repeat (60) @(negedge Clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_sequencer.md
REGISTER_SEQUENCER -- requirements
Module: register_sequencer

Interface
REQ-001 Parameter: COUNT_W, default 8, width of the step-count field.
REQ-002 Port: Clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: ReqValid  input  1  request offered.
REQ-005 Port: ReqReady  output  1  sequencer can accept a request.
REQ-006 Port: ReqOp  input  2  operation:
- 00 = step-down
- 01 = step-up
- 10 = load
- 11 = clear
REQ-007 Port: ReqCount  input  COUNT_W  step count for step ops; ignored for load/clear.
REQ-008 Port: ReqData  input  16  load value; ignored for other ops.
REQ-009 Port: RegE  output  1  enable to the downstream 16-bit register.
REQ-010 Port: RegFunSel  output  2  register function select:
- 00 = decrement
- 01 = increment
- 10 = load I
- 11 = clear
REQ-011 Port: RegI  output  16  register load data.
REQ-012 Port: Shadow  output  16  tracked copy of the register contents.
REQ-013 Port: Busy  output  1  high in every state except IDLE.
REQ-014 Port: Done  output  1  one-cycle completion pulse.
REQ-015 Port: Zero  output  1  high when Shadow == 16'h0000.

Function
REQ-016 The sequencer SHALL implement states INIT, IDLE, ISSUE, DONE; all outputs registered.
REQ-017 State transitions SHALL be:
- INIT -> IDLE after exactly one cycle.
- IDLE -> ISSUE on acceptance with pulse count > 0.
- IDLE -> DONE on acceptance of a step op with ReqCount == 0.
- ISSUE -> DONE after the last pulse.
- DONE -> IDLE after one cycle.
REQ-018 In INIT the sequencer SHALL drive RegE=1, RegFunSel=11 for one cycle, forcing the register and Shadow to 0.
REQ-019 ReqReady SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted when ReqValid && ReqReady at a rising edge; ReqOp/ReqCount/ReqData SHALL be captured at that edge and later input changes ignored.
REQ-021 Pulse count SHALL be:
- ReqCount for step ops.
- Exactly 1 for load and clear.
REQ-022 For acceptance at edge k with pulse count N>0:
- RegE SHALL be 1 during cycles k+1..k+N on consecutive cycles with no gaps.
- Done SHALL be 1 during cycle k+N+1.
- ReqReady SHALL return to 1 at cycle k+N+2.
REQ-023 For a step op with ReqCount==0, RegE SHALL stay 0, Done SHALL pulse in cycle k+1, and Shadow SHALL be unchanged.
REQ-024 While RegE=1:
- RegFunSel SHALL equal the captured op encoding.
- RegI SHALL equal captured ReqData for load, 0 otherwise.
REQ-025 While RegE=0, RegFunSel SHALL be 00 and RegI SHALL be 16'h0000.
REQ-026 Shadow SHALL update at every edge where RegE=1, by the same rule as the register:
- decrement: -1
- increment: +1
- load: RegI
- clear: 0
REQ-027 Shadow arithmetic SHALL wrap modulo 2^16 (0x0000-1 = 0xFFFF, 0xFFFF+1 = 0x0000), with no saturation or flag.
REQ-028 Zero SHALL be derived from registered Shadow and track it in the same cycle.
REQ-029 Done SHALL never be asserted in any cycle other than the DONE state.
REQ-030 ReqValid asserted while ReqReady=0 SHALL have no effect; the request SHALL be neither queued nor lost-acknowledged.

Reset
REQ-031 While Reset=1 at an edge, the next state SHALL be INIT and the outputs SHALL be:
- RegE=0, RegFunSel=00, RegI=0
- Shadow=0, Zero=1
- Busy=1, Done=0, ReqReady=0
REQ-032 After Reset deasserts, the first cycle SHALL be INIT (clear pulse), then IDLE with ReqReady=1.
REQ-033 Reset during ISSUE or DONE SHALL abort the operation:
- Remaining pulses are discarded.
- No Done pulse is issued.
- The INIT clear re-synchronises the register with Shadow.

Verification
REQ-034 Reset 2 cycles, release -> one cycle RegE=1/FunSel=11, then ReqReady=1, Shadow=0, Zero=1.
REQ-035 Load 0x1234 accepted at edge k -> RegE=1, FunSel=10, RegI=0x1234 in cycle k+1; Done in k+2; Shadow=0x1234.
REQ-036 Shadow=0x0001, step-down count 3 -> three consecutive FunSel=00 pulses; Shadow reaches 0xFFFE; Zero high only in the intermediate cycle where Shadow=0.
REQ-037 Shadow=0xFFFF, step-up count 1 -> Shadow=0x0000, Zero=1.
REQ-038 Step-up count 0 -> no RegE pulse, Done one cycle after acceptance, Shadow unchanged.
REQ-039 Step-up count 10, Reset asserted after 4 pulses -> no Done pulse; INIT clear issued; Shadow=0; ReqValid held during Busy is not accepted.
